// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants and types for the UART receive-side byte FIFO.
// Other UART blocks and benches take their default byte width and depth from here.
package uart_rx_fifo_pkg;

  localparam int UART_DATA_W = 8;
  localparam int FIFO_DEPTH  = 16;
  localparam int FIFO_ADDR_W = $clog2(FIFO_DEPTH);

  // Encoding is {read, write} so the helper below is a plain bit concatenation.
  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_BOTH  = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic wr, input logic rd);
    return fifo_op_e'({rd, wr});
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x DATA_W register array with one write port and one registered read port.
// Only the read register is reset; the storage array keeps its contents.
module uart_fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // NOTE: the array has no reset branch; clearing it would force it into flops and buys nothing.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)   r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/uart_rx_fifo.sv
// Byte buffer behind uart_rx: one write per rising edge of recieve_flag,
// one-cycle-latency rd_en/rd_valid read handshake, registered fill level and sticky overflow.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              baud_clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              recieve_flag,
  input  logic              rd_en,
  input  logic              clr_overflow,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);

  logic              r_flag_q;
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_empty, r_full, r_rd_valid, r_overflow;

  logic              w_wr_evt, w_rd_evt, w_wr_accept, w_drop;
  logic [ADDR_W:0]   w_count_nxt;
  fifo_op_e          w_op;

  assign w_wr_evt    = recieve_flag & ~r_flag_q;
  assign w_rd_evt    = rd_en & ~r_empty;
  // A read in the same cycle frees the head slot, so a full FIFO still accepts the byte.
  assign w_wr_accept = w_wr_evt & (~r_full | w_rd_evt);
  assign w_drop      = w_wr_evt & ~w_wr_accept;
  assign w_op        = fifo_op(w_wr_accept, w_rd_evt);

  always_comb begin
    w_count_nxt = r_count;
    unique case (w_op)
      OP_WRITE: w_count_nxt = r_count + CNT_ONE;
      OP_READ:  w_count_nxt = r_count - CNT_ONE;
      default:  w_count_nxt = r_count;
    endcase
  end

  // NOTE: every register below uses <= so all of them see the pre-edge values of each other.
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      r_flag_q   <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_flag_q   <= recieve_flag;
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_rd_evt)    r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count    <= w_count_nxt;
      r_empty    <= (w_count_nxt == '0);
      r_full     <= (w_count_nxt == CNT_FULL);
      r_rd_valid <= w_rd_evt;
      // A drop in the same cycle as a clear leaves the flag set.
      if (w_drop)            r_overflow <= 1'b1;
      else if (clr_overflow) r_overflow <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .i_clk   (baud_clk),
    .i_reset (reset),
    .i_we    (w_wr_accept & ~reset),
    .i_waddr (r_wr_ptr),
    .i_wdata (rx_data),
    .i_re    (w_rd_evt),
    .i_raddr (r_rd_ptr),
    .o_rdata (rd_data)
  );

  assign rd_valid = r_rd_valid;
  assign empty    = r_empty;
  assign full     = r_full;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule
